// File: rtl/updi_mem_access_ctrl.sv
// updi_mem_access_ctrl: sequences single-byte read/write requests into UPDI LDS/STS
// transactions on updi_interface, with bounded retry on ACK error or rx timeout.
`default_nettype none

module updi_mem_access_ctrl #(
  parameter int MAX_DATA_SIZE  = 16,
  parameter int DATA_ADDR_BITS = $clog2(MAX_DATA_SIZE),
  parameter int MAX_RETRIES    = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic                          req_write_i,
  input  logic [15:0]                   req_addr_i,
  input  logic [7:0]                    req_wdata_i,
  output logic                          rsp_valid_o,
  output logic [7:0]                    rsp_rdata_o,
  output logic [1:0]                    rsp_err_o,
  output logic [2:0]                    instruction_o,
  output logic [1:0]                    size_a_o,
  output logic [1:0]                    size_b_o,
  output logic [1:0]                    ptr_o,
  output logic [3:0]                    cs_addr_o,
  output logic                          sib_o,
  output logic [1:0]                    size_c_o,
  output logic [8*MAX_DATA_SIZE-1:0]    data_o,
  output logic [DATA_ADDR_BITS:0]       data_len_o,
  output logic [MAX_DATA_SIZE-1:0]      wait_ack_after_o,
  output logic                          tx_start_o,
  input  logic                          tx_ready_i,
  input  logic                          tx_done_i,
  output logic [DATA_ADDR_BITS-1:0]     rx_n_bytes_o,
  output logic                          rx_start_o,
  input  logic                          rx_ready_i,
  input  logic                          rx_done_i,
  input  logic                          rx_timeout_i,
  input  logic                          ack_error_i,
  input  logic [7:0]                    rx_fifo_data_i,
  input  logic                          rx_fifo_wr_en_i,
  output logic                          rx_fifo_full_o
);

  localparam logic [2:0] INSTR_LDS = 3'b000;
  localparam logic [2:0] INSTR_STS = 3'b010;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ACK     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TX_START = 3'd1,
    S_TX_WAIT  = 3'd2,
    S_RX_START = 3'd3,
    S_RX_WAIT  = 3'd4,
    S_RESP     = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  retry_q, retry_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;
  logic        write_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        loaded_q;

  logic        accept;
  logic        fail;
  logic [1:0]  fail_code;

  assign accept = (state_q == S_IDLE) && req_valid_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      retry_q  <= '0;
      rdata_q  <= '0;
      err_q    <= ERR_OK;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      loaded_q <= 1'b0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        write_q  <= req_write_i;
        addr_q   <= req_addr_i;
        wdata_q  <= req_wdata_i;
        loaded_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    fail        = 1'b0;
    fail_code   = ERR_OK;
    req_ready_o = 1'b0;
    tx_start_o  = 1'b0;
    rx_start_o  = 1'b0;
    rsp_valid_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready_o = rst_ni;
        if (req_valid_i) begin
          state_d = S_TX_START;
          retry_d = '0;
          rdata_d = '0;
          err_d   = ERR_OK;
        end
      end
      S_TX_START: begin
        tx_start_o = rst_ni && tx_ready_i;
        if (tx_ready_i) state_d = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (ack_error_i) begin
          fail      = 1'b1;
          fail_code = ERR_ACK;
        end else if (tx_done_i) begin
          state_d = write_q ? S_RESP : S_RX_START;
        end
      end
      S_RX_START: begin
        rx_start_o = rst_ni && rx_ready_i;
        if (rx_ready_i) state_d = S_RX_WAIT;
      end
      S_RX_WAIT: begin
        if (rx_fifo_wr_en_i) rdata_d = rx_fifo_data_i;
        // Timeout outranks a coincident rx_done: the byte count cannot be trusted.
        if (rx_timeout_i) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end else if (ack_error_i) begin
          fail      = 1'b1;
          fail_code = ERR_ACK;
        end else if (rx_done_i) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid_o = rst_ni;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (fail) begin
      rdata_d = '0;
      if (retry_q < 4'(MAX_RETRIES)) begin
        retry_d = retry_q + 4'd1;
        state_d = S_TX_START;
      end else begin
        err_d   = fail_code;
        state_d = S_RESP;
      end
    end
  end

  always_comb begin
    data_o           = '0;
    data_len_o       = '0;
    wait_ack_after_o = '0;
    rx_n_bytes_o     = '0;
    instruction_o    = write_q ? INSTR_STS : INSTR_LDS;
    if (loaded_q) begin
      data_o[15:0] = addr_q;
      if (write_q) begin
        data_o[23:16]         = wdata_q;
        data_len_o            = (DATA_ADDR_BITS+1)'(3);
        wait_ack_after_o[2:1] = 2'b11;
      end else begin
        data_len_o   = (DATA_ADDR_BITS+1)'(2);
        rx_n_bytes_o = DATA_ADDR_BITS'(1);
      end
    end
  end

  assign rsp_rdata_o    = rdata_q;
  assign rsp_err_o      = err_q;
  assign size_a_o       = 2'd1;
  assign size_b_o       = 2'd0;
  assign ptr_o          = 2'd0;
  assign cs_addr_o      = 4'd0;
  assign sib_o          = 1'b0;
  assign size_c_o       = 2'd0;
  assign rx_fifo_full_o = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_updi_mem_access_ctrl.sv
// Bench for updi_mem_access_ctrl: directed and random requests against an attempt-outcome model.
`default_nettype none

module tb_updi_mem_access_ctrl;

  localparam int MDS  = 16;
  localparam int DAB  = $clog2(MDS);
  localparam int MAXR = 2;
  localparam logic [2:0] LDS = 3'b000;
  localparam logic [2:0] STS = 3'b010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 0, req_write = 0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic tx_ready = 0, tx_done = 0, rx_ready = 0, rx_done = 0, rx_timeout = 0, ack_error = 0;
  logic [7:0] rx_fifo_data = '0;
  logic rx_fifo_wr_en = 0;

  logic req_ready, rsp_valid, tx_start, rx_start, sib, rx_fifo_full;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err, size_a, size_b, ptr, size_c;
  logic [2:0] instruction;
  logic [3:0] cs_addr;
  logic [8*MDS-1:0] data;
  logic [DAB:0] data_len;
  logic [MDS-1:0] wait_ack_after;
  logic [DAB-1:0] rx_n_bytes;

  int n_tests = 0, n_fail = 0;
  int tx_cnt = 0, rx_cnt = 0, rsp_cnt = 0;

  updi_mem_access_ctrl #(.MAX_DATA_SIZE(MDS), .MAX_RETRIES(MAXR)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .instruction_o(instruction), .size_a_o(size_a), .size_b_o(size_b), .ptr_o(ptr),
    .cs_addr_o(cs_addr), .sib_o(sib), .size_c_o(size_c),
    .data_o(data), .data_len_o(data_len), .wait_ack_after_o(wait_ack_after),
    .tx_start_o(tx_start), .tx_ready_i(tx_ready), .tx_done_i(tx_done),
    .rx_n_bytes_o(rx_n_bytes), .rx_start_o(rx_start), .rx_ready_i(rx_ready),
    .rx_done_i(rx_done), .rx_timeout_i(rx_timeout), .ack_error_i(ack_error),
    .rx_fifo_data_i(rx_fifo_data), .rx_fifo_wr_en_i(rx_fifo_wr_en), .rx_fifo_full_o(rx_fifo_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (tx_start) tx_cnt++;
    if (rx_start) rx_cnt++;
    if (rsp_valid) rsp_cnt++;
    if (tx_start && rx_start) chk("tx_rx_overlap", 32'(rx_start), 32'd0);
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
    chk({tag, "_starts"}, {30'd0, tx_start, rx_start}, 0);
    chk({tag, "_data_any"}, 32'(|data), 0);
    chk({tag, "_data_len"}, 32'(data_len), 0);
    chk({tag, "_wack"}, 32'(wait_ack_after), 0);
    chk({tag, "_instr"}, 32'(instruction), 32'(LDS));
    chk({tag, "_fifo_full"}, 32'(rx_fifo_full), 0);
  endtask

  // pat holds one 2-bit outcome per attempt: 0 ok, 1 ack_error, 2 rx_timeout, 3 rx_done+rx_timeout
  task automatic run_txn(input bit wr, input logic [15:0] a, input logic [7:0] wd,
                         input logic [7:0] rb, input logic [7:0] pat, input int rdy_dly, input bit poke);
    int codes[4];
    int att, erx, dly;
    bit ok;
    logic [1:0] eerr;
    logic [7:0] erd;
    logic [31:0] ed;
    int tx0, rx0, rsp0;

    for (int i = 0; i < 4; i++) begin
      codes[i] = int'(pat[2*i +: 2]);
      if (wr && codes[i] > 1) codes[i] = 1;
    end
    ok = 0; eerr = 0; att = 0; erx = 0;
    for (int i = 0; i <= MAXR; i++) begin
      att++;
      if (!wr && codes[i] != 1) erx++;
      if (codes[i] == 0) begin ok = 1; break; end
      eerr = (codes[i] == 1) ? 2'd1 : 2'd2;
    end
    if (ok) eerr = 0;
    erd = (ok && !wr) ? rb : 8'd0;
    ed = {8'd0, (wr ? wd : 8'd0), a};

    tx0 = tx_cnt; rx0 = rx_cnt; rsp0 = rsp_cnt;
    req_valid = 1; req_write = wr; req_addr = a; req_wdata = wd;
    #1 chk("req_ready_idle", 32'(req_ready), 1);
    tick();
    req_valid = 0;

    for (int i = 0; i < att; i++) begin
      tx_ready = 0;
      for (int k = 0; k < rdy_dly; k++) begin
        if (poke) begin req_valid = 1; req_addr = ~a; req_write = ~wr; end
        #1 chk("tx_hold", 32'(tx_start), 0);
        chk("busy_ready", 32'(req_ready), 0);
        tick();
      end
      req_valid = 0;
      tx_ready = 1;
      #1 chk("tx_start", 32'(tx_start), 1);
      chk("data_lo", data[31:0], ed);
      chk("data_hi", 32'(|data[8*MDS-1:32]), 0);
      chk("data_len", 32'(data_len), wr ? 32'd3 : 32'd2);
      chk("wack", 32'(wait_ack_after), wr ? 32'h6 : 32'h0);
      chk("instr", 32'(instruction), wr ? 32'(STS) : 32'(LDS));
      chk("rx_n_bytes", 32'(rx_n_bytes), wr ? 32'd0 : 32'd1);
      tick();
      tx_ready = 0;
      dly = $urandom_range(0, 2);
      for (int k = 0; k < dly; k++) begin
        #1 chk("no_early_rsp", 32'(rsp_valid), 0);
        tick();
      end
      if (codes[i] == 1) begin
        ack_error = 1; tick(); ack_error = 0;
      end else begin
        tx_done = 1; tick(); tx_done = 0;
        if (!wr) begin
          dly = $urandom_range(0, 2);
          for (int k = 0; k < dly; k++) begin
            #1 chk("rx_hold", 32'(rx_start), 0);
            tick();
          end
          rx_ready = 1;
          #1 chk("rx_start", 32'(rx_start), 1);
          tick();
          rx_ready = 0;
          rx_fifo_wr_en = 1; rx_fifo_data = (codes[i] == 0) ? rb : ~rb;
          tick();
          rx_fifo_wr_en = 0;
          if (codes[i] == 2) rx_timeout = 1;
          else if (codes[i] == 3) begin rx_timeout = 1; rx_done = 1; end
          else rx_done = 1;
          tick();
          rx_timeout = 0; rx_done = 0;
        end
      end
    end

    #1 chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_err", 32'(rsp_err), 32'(eerr));
    chk("rsp_rdata", 32'(rsp_rdata), 32'(erd));
    tick();
    #1 chk("rsp_pulse_end", 32'(rsp_valid), 0);
    chk("ready_after_rsp", 32'(req_ready), 1);
    chk("tx_pulses", 32'(tx_cnt - tx0), 32'(att));
    chk("rx_pulses", 32'(rx_cnt - rx0), 32'(erx));
    chk("rsp_count", 32'(rsp_cnt - rsp0), 1);
  endtask

  task automatic reset_in_rx_wait();
    int rsp0;
    rsp0 = rsp_cnt;
    req_valid = 1; req_write = 0; req_addr = 16'h2345;
    tick(); req_valid = 0;
    tx_ready = 1; tick(); tx_ready = 0;
    tx_done = 1; tick(); tx_done = 0;
    rx_ready = 1; tick(); rx_ready = 0;
    rx_fifo_wr_en = 1; rx_fifo_data = 8'h99; tick(); rx_fifo_wr_en = 0;
    rst_n = 0; rx_done = 1;
    tick();
    rx_done = 0;
    #1 chk_reset_outputs("midrst");
    rst_n = 1;
    tick();
    #1 chk("ready_after_rst", 32'(req_ready), 1);
    chk("no_rsp_on_abort", 32'(rsp_cnt - rsp0), 0);
  endtask

  initial begin
    rst_n = 0;
    repeat (3) tick();
    #1 chk_reset_outputs("reset");
    chk("size_a", 32'(size_a), 1);
    chk("fixed_zero", {20'd0, size_b, ptr, cs_addr, sib, size_c}, 0);
    rst_n = 1;
    tick();
    #1 chk("ready_after_release", 32'(req_ready), 1);

    run_txn(1'b1, 16'h0F01, 8'hA5, 8'h00, 8'h00, 0, 1'b0);
    run_txn(1'b0, 16'h1100, 8'h00, 8'h3C, 8'h00, 0, 1'b0);
    run_txn(1'b1, 16'h4242, 8'h5A, 8'h00, 8'h05, 1, 1'b0);
    run_txn(1'b0, 16'h8001, 8'h00, 8'h77, 8'h2A, 0, 1'b0);
    run_txn(1'b0, 16'h8002, 8'h00, 8'h66, 8'h3F, 0, 1'b0);
    run_txn(1'b0, 16'h0003, 8'h00, 8'hC3, 8'h0E, 2, 1'b0);
    run_txn(1'b1, 16'hBEEF, 8'h11, 8'h00, 8'h00, 10, 1'b1);
    reset_in_rx_wait();
    run_txn(1'b0, 16'hCAFE, 8'h00, 8'hE1, 8'h00, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      run_txn(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/updi_mem_access_ctrl.md
# updi_mem_access_ctrl

Sequencer sitting above `updi_interface` that turns single-byte memory requests (read/write at a 16-bit address) into UPDI LDS/STS transactions. It drives the instruction, data buffer and tx/rx handshakes of `updi_interface`, sinks the received byte from its rx output FIFO port, retries on ACK error or rx timeout, and returns one response per request.

## Interface

**Parameters**

- `MAX_DATA_SIZE`, default 16: must match the `updi_interface` instance; must be ≥ 3.
- `DATA_ADDR_BITS`, default `$clog2(MAX_DATA_SIZE)`: buffer index width.
- `MAX_RETRIES`, default 2: extra attempts after the first failure (0..15).

**Ports**

- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller accepts the request this cycle.
- `req_write` in 1: 1 selects STS (write), 0 selects LDS (read).
- `req_addr` in 16: target address.
- `req_wdata` in 8: write byte.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out 8: read byte; 0 for writes and for errors.
- `rsp_err` out 2: 0 ok, 1 ack_error, 2 rx_timeout.
- `instruction` out `updi_instruction`: STS or LDS.
- `size_a` out 2: address size; fixed 1 (word).
- `size_b` out 2: data size; fixed 0 (byte).
- `ptr`, `cs_addr`, `sib`, `size_c` out 2/4/1/2: fixed 0.
- `data` out 8 × `MAX_DATA_SIZE`: tx buffer.
- `data_len` out `DATA_ADDR_BITS+1`: tx byte count.
- `wait_ack_after` out `MAX_DATA_SIZE`: per-index ACK wait mask.
- `tx_start` out 1; `tx_ready` in 1; `tx_done` in 1.
- `rx_n_bytes` out `DATA_ADDR_BITS`; `rx_start` out 1; `rx_ready` in 1; `rx_done` in 1; `rx_timeout` in 1; `ack_error` in 1.
- `rx_fifo_data` in 8; `rx_fifo_wr_en` in 1; `rx_fifo_full` out 1: connects to `updi_interface` `out_rx_fifo_*`.

## Operation

**Request latch.** The request is latched on `req_valid && req_ready`. `req_ready` is 1 only in IDLE. The latched request drives the following until the response:

- `data[0]` = `addr[7:0]`, `data[1]` = `addr[15:8]`; remaining entries 0.
- STS: `data[2]` = `wdata`, `data_len` = 3, `wait_ack_after` bits 1 and 2 set.
- LDS: `data_len` = 2, `wait_ack_after` = 0, `rx_n_bytes` = 1.

**FSM states:** IDLE, TX_START, TX_WAIT, RX_START, RX_WAIT, RESP.

- IDLE → TX_START on accept; retry counter cleared.
- TX_START: `tx_start`=1 while `tx_ready`=1 (single cycle), then → TX_WAIT. Held waiting while `tx_ready`=0.
- TX_WAIT:
  - `ack_error` → failure.
  - `tx_done`: STS → RESP with err 0; LDS → RX_START.
- RX_START: `rx_start`=1 for one cycle once `rx_ready`=1, then → RX_WAIT.
- RX_WAIT:
  - `rx_fifo_wr_en` captures `rx_fifo_data` into the rdata register.
  - `rx_timeout` → failure.
  - `rx_done` → RESP with err 0.
  - If `rx_done` and `rx_timeout` occur in the same cycle, timeout wins.
- Failure: if retries < `MAX_RETRIES`, increment the counter and go to TX_START. Otherwise go to RESP with the error code (ack_error=1, timeout=2) and rdata 0.
- RESP: `rsp_valid`=1 for exactly one cycle → IDLE.

**Other behaviour.**

- `rx_fifo_full` is tied to 0; the controller always sinks.
- `ack_error` outside TX_WAIT/RX_WAIT is ignored.
- Reset mid-transaction returns to IDLE immediately. No response is emitted for the aborted request.

## Timing

**Reset values:**

- `req_ready`=0 during reset, 1 the cycle after release.
- `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
- `tx_start`=0, `rx_start`=0.
- `data` all 0, `data_len`=0, `wait_ack_after`=0.
- `instruction`=LDS.
- `rx_fifo_full`=0.

**Latency and handshake rules:**

- `tx_start` is asserted no earlier than the cycle after accept.
- Fixed latency from `tx_done` (STS) or `rx_done` (LDS) to `rsp_valid` is 1 cycle.
- `tx_start` and `rx_start` are never asserted together. Each is a one-cycle pulse per attempt.
- Buffer outputs are stable from accept until RESP exits.
- A new request can be accepted in the cycle after `rsp_valid`.

## Test plan

1. STS `addr`=0x0F01, `wdata`=0xA5, stub ACKs OK:
   - `data`={01,0F,A5}, `data_len`=3, `wait_ack_after`=0b110.
   - One `tx_start`; `rsp_valid` one cycle after `tx_done`; `rsp_err`=0.
2. LDS `addr`=0x1100, stub returns 0x3C:
   - `data_len`=2, `rx_start` after `tx_done`.
   - `rsp_rdata`=0x3C, `rsp_err`=0.
3. STS, `ack_error` on the first two attempts, then OK (`MAX_RETRIES`=2) → exactly 3 `tx_start` pulses; `rsp_err`=0.
4. LDS with `rx_timeout` on every attempt → 3 attempts, then `rsp_err`=2, `rsp_rdata`=0. `rx_done`+`rx_timeout` in the same cycle → error.
5. Hold `tx_ready`=0 for 10 cycles after accept → `tx_start` stays 0, then pulses once. `req_ready`=0 throughout; a second `req_valid` is not accepted until after `rsp_valid`.
6. Assert `rst`=0 in RX_WAIT → next cycle all outputs at reset values, no `rsp_valid`; a subsequent request completes normally.
